// File: rtl/rr_arbiter_pkt_mux.sv
// Packet-aware round-robin arbiter: merges NUM_CH valid/ready packet streams onto one
// registered output without interleaving beats of different packets.
module rr_arbiter_pkt_mux #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DWIDTH = 512,
  parameter int unsigned EWIDTH = 6,
  parameter int unsigned CWIDTH = $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*DWIDTH-1:0]   in_data,
  input  logic [NUM_CH-1:0]          in_valid,
  input  logic [NUM_CH-1:0]          in_sop,
  input  logic [NUM_CH-1:0]          in_eop,
  input  logic [NUM_CH*EWIDTH-1:0]   in_empty,
  output logic [NUM_CH-1:0]          in_ready,
  output logic [DWIDTH-1:0]          out_data,
  output logic                       out_valid,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic [EWIDTH-1:0]          out_empty,
  output logic [CWIDTH-1:0]          out_channel,
  input  logic                       out_ready,
  output logic                       busy
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e              r_state, w_state_next;
  logic [CWIDTH-1:0]   r_lock_ch, w_lock_ch_next;
  logic [CWIDTH-1:0]   r_last, w_last_next;

  logic [DWIDTH-1:0]   r_out_data;
  logic                r_out_valid, r_out_sop, r_out_eop;
  logic [EWIDTH-1:0]   r_out_empty;
  logic [CWIDTH-1:0]   r_out_channel;

  logic [NUM_CH-1:0]   w_elig;
  logic                w_found, w_have, w_can_load, w_xfer;
  logic [CWIDTH-1:0]   w_idx, w_sel, w_ch;
  logic [DWIDTH-1:0]   w_data;
  logic [EWIDTH-1:0]   w_empty;
  logic                w_valid, w_sop, w_eop;

  assign w_elig     = in_valid & in_sop;
  assign w_can_load = !r_out_valid | out_ready;

  // Round-robin search starting just above the last granted channel.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      w_idx = CWIDTH'((32'(r_last) + k) % NUM_CH);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign w_have = (r_state == StLocked) | w_found;
  assign w_ch   = (r_state == StLocked) ? r_lock_ch : w_sel;

  always_comb begin
    w_data   = '0;
    w_empty  = '0;
    w_valid  = 1'b0;
    w_sop    = 1'b0;
    w_eop    = 1'b0;
    in_ready = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_ch == CWIDTH'(i)) begin
        w_data      = in_data[i*DWIDTH +: DWIDTH];
        w_empty     = in_empty[i*EWIDTH +: EWIDTH];
        w_valid     = in_valid[i];
        w_sop       = in_sop[i];
        w_eop       = in_eop[i];
        in_ready[i] = w_have & w_can_load;
      end
    end
  end

  assign w_xfer = w_have & w_can_load & w_valid;

  always_comb begin
    w_state_next   = r_state;
    w_lock_ch_next = r_lock_ch;
    w_last_next    = r_last;
    unique case (r_state)
      StIdle: begin
        if (w_xfer) begin
          w_last_next = w_sel;
          if (!w_eop) begin
            w_state_next   = StLocked;
            w_lock_ch_next = w_sel;
          end
        end
      end
      StLocked: begin
        // A stray sop from the owner is passed through; only eop releases the lock.
        if (w_xfer && w_eop) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_lock_ch     <= '0;
      r_last        <= CWIDTH'(NUM_CH - 1);
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_out_sop     <= 1'b0;
      r_out_eop     <= 1'b0;
      r_out_empty   <= '0;
      r_out_channel <= '0;
    end else begin
      r_state   <= w_state_next;
      r_lock_ch <= w_lock_ch_next;
      r_last    <= w_last_next;
      if (w_xfer) begin
        r_out_data    <= w_data;
        r_out_valid   <= 1'b1;
        r_out_sop     <= w_sop;
        r_out_eop     <= w_eop;
        r_out_empty   <= w_empty;
        r_out_channel <= w_ch;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign out_sop     = r_out_sop;
  assign out_eop     = r_out_eop;
  assign out_empty   = r_out_empty;
  assign out_channel = r_out_channel;
  assign busy        = (r_state == StLocked);

endmodule

// File: doc/rr_arbiter_pkt_mux.md
Name: rr_arbiter_pkt_mux

Overview:
- N-channel packet-aware round-robin arbiter with integrated data mux and one-entry registered output stage; generalises the 2-input sop/eop grant-locking arbiter.
- Merges NUM_CH Avalon-ST-style packet streams (valid/ready, sop/eop/empty) onto one output without interleaving beats of different packets.
- Sits in front of shared pipelines (e.g. merging per-port packet FIFOs into one parser/matcher lane).

Parameters:
- NUM_CH, 4, number of input channels (>=2).
- DWIDTH, 512, data bus width per channel.
- EWIDTH, 6, empty-field width per channel.
- CWIDTH, $clog2(NUM_CH), width of out_channel.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_data  in  NUM_CH*DWIDTH  channel i at bits [i*DWIDTH +: DWIDTH].
- in_valid  in  NUM_CH  beat valid per channel.
- in_sop  in  NUM_CH  start of packet per channel.
- in_eop  in  NUM_CH  end of packet per channel.
- in_empty  in  NUM_CH*EWIDTH  empty bytes on eop beat, channel i at [i*EWIDTH +: EWIDTH].
- in_ready  out  NUM_CH  beat accepted when in_valid[i] & in_ready[i].
- out_data  out  DWIDTH  muxed data.
- out_valid  out  1  output beat valid.
- out_sop  out  1  start of packet.
- out_eop  out  1  end of packet.
- out_empty  out  EWIDTH  empty bytes.
- out_channel  out  CWIDTH  source channel of current beat.
- out_ready  in  1  downstream accept.
- busy  out  1  high while a packet is locked (mid-packet).

Behaviour:
- Single clock domain (clk); reset is synchronous, active-high (rst).
- Reset: out_valid=0, out_sop=0, out_eop=0, out_data/out_empty/out_channel=0, busy=0, lock=0, last-grant pointer=NUM_CH-1 (channel 0 highest priority after reset).
- can_load = !out_valid | out_ready (output register empty or draining this cycle).
- State machine: IDLE (lock=0), LOCKED (lock=1, lock_ch holds owner).
- IDLE: eligible[i] = in_valid[i] & in_sop[i]. Round-robin select: first eligible channel searching upward from (last+1) mod NUM_CH, wrapping. in_ready[sel]=can_load; all other in_ready=0. Non-sop beats on unlocked channels are never eligible and stall (in_ready=0); they are not dropped.
- IDLE transfer (eligible, can_load): beat loaded into output register next edge; last<=sel. If in_eop[sel]=0 -> LOCKED, lock_ch<=sel, busy=1 from next cycle. If sop&eop same beat (single-beat pkt) -> stay IDLE; next arbitration may occur the following cycle.
- LOCKED: in_ready[lock_ch]=can_load, all others 0; no arbitration. On transfer of beat with in_eop[lock_ch]=1 -> IDLE, busy=0 next cycle. Rotation pointer not changed while locked.
- Owner idle mid-packet (in_valid low): lock held indefinitely; no other channel granted.
- sop seen on owner while LOCKED (missing eop): beat passed through unchanged, lock kept; no recovery.
- Output register: loads {data, sop, eop, empty, channel} on transfer; out_valid<=1. If out_ready & !transfer, out_valid<=0. Held stable while out_valid & !out_ready. Latency input-accept to out_valid = 1 cycle; full throughput 1 beat/cycle under continuous out_ready, including back-to-back packets from different channels with no bubble.
- in_ready is combinational from in_valid/in_sop/lock/out_valid/out_ready; out_* are registered only.
- Reset mid-packet: lock cleared, output stage emptied; upstream re-synchronises on next sop.

Test Plan:
- NUM_CH=4, all channels present 3-beat packets at sop simultaneously, out_ready=1 -> out_channel sequence 0,0,0,1,1,1,2,2,2,3,3,3; no interleave; 12 beats in 12 consecutive cycles, first out_valid 1 cycle after first accept.
- Ch1 sends 5-beat packet; ch2 raises sop on beat 2 -> ch2 in_ready=0 until ch1 eop accepted; ch2 sop granted on the cycle after the eop transfer cycle; busy high for 4 cycles.
- Single-beat packets (sop&eop) on ch0 and ch3 every cycle -> alternating grants 0,3,0,3; busy stays 0.
- out_ready toggles 1,0,0,1 during a 4-beat ch2 packet -> output data held stable while stalled, no beat lost or duplicated, in_ready[2]=0 while out_valid & !out_ready.
- Ch1 presents non-sop beat while IDLE, ch2 presents sop -> ch2 granted, ch1 in_ready stays 0, ch1 beat never appears on output.
- Assert rst on beat 2 of a 4-beat ch0 packet -> next cycle out_valid=0, busy=0; ch3 sop granted on the cycle after rst deasserts (pointer reset, ch0 not prioritised over lone request).
